// File: rtl/input_row_fetch_ctrl_pkg.sv
// Shared constants, FSM encoding and window address helper for the input-row fetch scheduler.
package input_row_fetch_ctrl_pkg;

    localparam int unsigned C_S_AXI_ID_WIDTH   = 3;
    localparam int unsigned C_S_AXI_ADDR_WIDTH = 32;
    localparam int unsigned C_S_AXI_DATA_WIDTH = 64;
    localparam int unsigned C_S_AXI_BURST_LEN  = 8;
    localparam int unsigned ROW_STRIDE_BYTES   = 64;
    localparam int unsigned LAYER_STRIDE_BYTES = 4096;
    localparam int unsigned ROWS_PER_FETCH     = 3;

    localparam int unsigned DIM_W             = 10;
    localparam int unsigned ARLEN_W           = 8;
    localparam int unsigned WR_ADDR_W         = 8;
    localparam int unsigned K_W               = 2;
    localparam int unsigned BANK_WORDS        = 32;
    localparam int unsigned BEAT_BYTES        = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES       = C_S_AXI_BURST_LEN * BEAT_BYTES;
    localparam int unsigned BEATS_PER_WINDOW  = ROWS_PER_FETCH * ROW_STRIDE_BYTES / BEAT_BYTES;
    localparam int unsigned BURSTS_PER_WINDOW = BEATS_PER_WINDOW / C_S_AXI_BURST_LEN;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_WAIT_BANK = 3'd2;
    localparam logic [2:0] S_ISSUE_AR  = 3'd3;
    localparam logic [2:0] S_WAIT_DATA = 3'd4;
    localparam logic [2:0] S_COMMIT    = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_CHECK     = S_CHECK,
        ST_WAIT_BANK = S_WAIT_BANK,
        ST_ISSUE_AR  = S_ISSUE_AR,
        ST_WAIT_DATA = S_WAIT_DATA,
        ST_COMMIT    = S_COMMIT,
        ST_DONE      = S_DONE
    } state_e;

    // Byte address of burst k of the window (layer, row); wraps modulo 2^32.
    function automatic logic [C_S_AXI_ADDR_WIDTH-1:0] window_addr(
        input logic [C_S_AXI_ADDR_WIDTH-1:0] base,
        input logic [DIM_W-1:0]              layer,
        input logic [DIM_W-1:0]              row,
        input logic [K_W-1:0]                k
    );
        return base
             + C_S_AXI_ADDR_WIDTH'(layer) * C_S_AXI_ADDR_WIDTH'(LAYER_STRIDE_BYTES)
             + C_S_AXI_ADDR_WIDTH'(row)   * C_S_AXI_ADDR_WIDTH'(ROW_STRIDE_BYTES)
             + C_S_AXI_ADDR_WIDTH'(k)     * C_S_AXI_ADDR_WIDTH'(BURST_BYTES);
    endfunction

endpackage

// File: rtl/input_row_fetch_ctrl_bank_tracker.sv
// Ping-pong bank bookkeeping: full flags, loaded window ids and the write-bank pointer.
module pingpong_bank_tracker
    import input_row_fetch_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 commit_i,
    input  logic [DIM_W-1:0]     layer_id_i,
    input  logic [DIM_W-1:0]     row_id_i,
    input  logic [1:0]           bank_release_i,
    output logic                 ptr_o,
    output logic [1:0]           bank_full_o,
    output logic [2*DIM_W-1:0]   bank_layer_id_o,
    output logic [2*DIM_W-1:0]   bank_row_id_o
);

    logic               ptr_q;
    logic [1:0]         full_q;
    logic [1:0]         full_d;
    logic [1:0]         set_mask_c;
    logic [2*DIM_W-1:0] layer_q;
    logic [2*DIM_W-1:0] row_q;

    // A commit on the bank being released in the same cycle keeps the bank full.
    always_comb begin
        set_mask_c = 2'b00;
        if (commit_i) begin
            set_mask_c = ptr_q ? 2'b10 : 2'b01;
        end
        full_d = (full_q & ~bank_release_i) | set_mask_c;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q   <= 1'b0;
            full_q  <= 2'b00;
            layer_q <= '0;
            row_q   <= '0;
        end else begin
            full_q <= full_d;
            if (commit_i) begin
                ptr_q <= ~ptr_q;
                if (ptr_q) begin
                    layer_q[2*DIM_W-1:DIM_W] <= layer_id_i;
                    row_q[2*DIM_W-1:DIM_W]   <= row_id_i;
                end else begin
                    layer_q[DIM_W-1:0] <= layer_id_i;
                    row_q[DIM_W-1:0]   <= row_id_i;
                end
            end
        end
    end

    assign ptr_o           = ptr_q;
    assign bank_full_o     = full_q;
    assign bank_layer_id_o = layer_q;
    assign bank_row_id_o   = row_q;

endmodule

// File: rtl/input_row_fetch_ctrl.sv
// AXI4 read scheduler: loads 3-row windows of each input layer into a ping-pong BRAM,
// one burst in flight, throttled by the consumer's bank releases.
module input_row_fetch_ctrl
    import input_row_fetch_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_address,
    input  logic [DIM_W-1:0]              no_of_input_layers,
    input  logic [DIM_W-1:0]              input_layer_row_size,
    output logic                          busy,
    output logic                          done,
    output logic                          rresp_err,
    output logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_arid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
    output logic [ARLEN_W-1:0]            M_axi_arlen,
    output logic                          M_axi_arvalid,
    input  logic                          M_axi_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
    input  logic [1:0]                    M_axi_rresp,
    input  logic                          M_axi_rlast,
    input  logic                          M_axi_rvalid,
    output logic                          M_axi_rready,
    output logic [WR_ADDR_W-1:0]          blk_ram_wr_addr,
    output logic                          blk_ram_wr_en,
    output logic [1:0]                    bank_full,
    output logic [2*DIM_W-1:0]            bank_layer_id,
    output logic [2*DIM_W-1:0]            bank_row_id,
    input  logic [1:0]                    bank_release
);

    state_e                        state_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] base_q;
    logic [DIM_W-1:0]              n_q;
    logic [DIM_W-1:0]              rows_q;
    logic [DIM_W-1:0]              layer_q;
    logic [DIM_W-1:0]              row_q;
    logic [K_W-1:0]                k_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                          arvalid_q;
    logic                          rready_q;
    logic [WR_ADDR_W-1:0]          wr_addr_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          err_q;

    logic                          ptr_c;
    logic                          commit_c;
    logic                          r_hs_c;
    logic                          last_layer_c;
    logic [DIM_W-1:0]              row_next_c;
    logic [K_W-1:0]                k_next_c;
    logic [C_S_AXI_ADDR_WIDTH-1:0] addr_next_c;
    logic                          unused_rdata_c;

    // Read data goes straight to the BRAM in the parent.
    assign unused_rdata_c = ^M_axi_rdata;

    assign commit_c     = (state_q == ST_COMMIT);
    assign r_hs_c       = rready_q & M_axi_rvalid;
    assign last_layer_c = (layer_q == n_q - DIM_W'(1));
    assign row_next_c   = row_q + DIM_W'(1);
    assign k_next_c     = (state_q == ST_WAIT_DATA) ? k_q + K_W'(1) : '0;
    assign addr_next_c  = window_addr(base_q, layer_q, row_q, k_next_c);

    pingpong_bank_tracker u_bank_tracker (
        .clk             (clk),
        .reset_n         (reset_n),
        .commit_i        (commit_c),
        .layer_id_i      (layer_q),
        .row_id_i        (row_q),
        .bank_release_i  (bank_release),
        .ptr_o           (ptr_c),
        .bank_full_o     (bank_full),
        .bank_layer_id_o (bank_layer_id),
        .bank_row_id_o   (bank_row_id)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            n_q       <= '0;
            rows_q    <= '0;
            layer_q   <= '0;
            row_q     <= '0;
            k_q       <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= axi_address;
                        n_q     <= no_of_input_layers;
                        rows_q  <= input_layer_row_size;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    layer_q <= '0;
                    row_q   <= '0;
                    if (n_q == '0 || rows_q < DIM_W'(ROWS_PER_FETCH)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT_BANK;
                    end
                end
                ST_WAIT_BANK: begin
                    if (!bank_full[ptr_c]) begin
                        k_q       <= '0;
                        araddr_q  <= addr_next_c;
                        arvalid_q <= 1'b1;
                        wr_addr_q <= WR_ADDR_W'(ptr_c) * WR_ADDR_W'(BANK_WORDS);
                        state_q   <= ST_ISSUE_AR;
                    end
                end
                ST_ISSUE_AR: begin
                    if (M_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (r_hs_c) begin
                        wr_addr_q <= wr_addr_q + WR_ADDR_W'(1);
                        if (M_axi_rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (M_axi_rlast) begin
                            rready_q <= 1'b0;
                            if (k_q == K_W'(BURSTS_PER_WINDOW - 1)) begin
                                state_q <= ST_COMMIT;
                            end else begin
                                k_q       <= k_next_c;
                                araddr_q  <= addr_next_c;
                                arvalid_q <= 1'b1;
                                state_q   <= ST_ISSUE_AR;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    // Layers iterate fastest; the row advances when the layer wraps.
                    if (last_layer_c) begin
                        layer_q <= '0;
                        row_q   <= row_next_c;
                        if (row_next_c > rows_q - DIM_W'(ROWS_PER_FETCH)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT_BANK;
                        end
                    end else begin
                        layer_q <= layer_q + DIM_W'(1);
                        state_q <= ST_WAIT_BANK;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rresp_err       = err_q;
    assign M_axi_arid      = C_S_AXI_ID_WIDTH'(1);
    assign M_axi_arlen     = ARLEN_W'(C_S_AXI_BURST_LEN - 1);
    assign M_axi_araddr    = araddr_q;
    assign M_axi_arvalid   = arvalid_q;
    assign M_axi_rready    = rready_q;
    assign blk_ram_wr_addr = wr_addr_q;
    assign blk_ram_wr_en   = M_axi_rvalid & M_axi_rready;

endmodule
